ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Parametrised successor instruction-fetch unit for the rvseed core. It issues single-beat AXI read requests from an internal fetch PC, keeping up to OST_NUM reads outstanding. Returned instructions go into a PC+instruction queue that the IDU drains through a valid/ready handshake. Branch/jump redirects flush the queue and discard in-flight responses with a drop counter, so no PC compare is needed downstream.

Parameters:
CPU_W, 32, PC and instruction width
ADDR_W, 32, AXI address width
ID_W, 4, AXI ID width; all requests use ARID = FETCH_ID
FETCH_ID, 0, constant ARID value
OST_NUM, 4, max outstanding AR transactions (power of 2, >=1)
Q_DEPTH, 4, instruction queue entries (power of 2, >=2)
BASE_ADDR, 32'h0, added to fetch PC to form ARADDR
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
enable  in  1  fetch enable; when low, no new AR issued
redirect_en  in  1  branch/jump taken this cycle
redirect_pc  in  CPU_W  new fetch PC
arvalid  out  1  AR valid
arready  in  1  AR ready
arid  out  ID_W  = FETCH_ID
araddr  out  ADDR_W  BASE_ADDR + request PC
arlen  out  8  = 0
arsize  out  3  = 3'b010
arburst  out  2  = 2'b01 (INCR)
rvalid  in  1  R valid
rready  out  1  constant 1
rdata  in  CPU_W  instruction
rresp  in  2  response
rlast  in  1  ignored (single beat)
inst_valid  out  1  queue head valid to IDU
inst_ready  in  1  IDU accepts head
inst_pc  out  CPU_W  head PC
inst_data  out  CPU_W  head instruction
ost_cnt  out  log2(OST_NUM)+1  live outstanding count (debug)

Behaviour:
- Reset: fetch_pc=RESET_PC, arvalid=0, queue empty, inst_valid=0, ost_cnt=0, drop_cnt=0. inst_pc/inst_data=0 while empty.
- Credit rule: a new AR may be raised only if enable & ~redirect_en & (ost_cnt < OST_NUM) & (ost_cnt + q_count < Q_DEPTH). Every accepted response therefore has a free queue slot; queue overflow is impossible.
- AR: registered. arvalid/araddr hold stable until arready (AXI rule). On arvalid&arready: ost_cnt+1, push request PC into the PC side-FIFO (depth OST_NUM), fetch_pc += 4. If the credit rule holds on the handshake cycle, the next request goes out back-to-back the next cycle.
- R: rvalid&rready with drop_cnt>0 -> response discarded, drop_cnt-1, PC side-FIFO popped. Otherwise it is written into the queue with the popped PC, and ost_cnt-1. Responses return in order (single ID).
- Queue: inst_valid = ~empty. Pop on inst_valid&inst_ready. A write into the empty queue is visible 1 cycle later. Simultaneous push and pop at full/empty is legal; the count is unchanged.
- Redirect (highest priority): the next cycle sees an empty queue, fetch_pc=redirect_pc, drop_cnt = drop_cnt + ost_cnt (ost_cnt cleared into drop), ost_cnt=0. An AR pending but not yet accepted is counted as outstanding and is allowed to complete (arvalid is not withdrawn); its response is dropped. The first new AR is issued the cycle after the redirect. A response arriving in the redirect cycle is dropped. An inst pop in the redirect cycle is allowed.
- Back-to-back redirects accumulate drop_cnt correctly. Its width is log2(OST_NUM)+1 and it never exceeds OST_NUM.
- enable low: the current AR completes and responses are still accepted; no new AR is issued.
- Async reset mid-transaction clears all state. The bus is assumed reset together with this block.

Optional Feature:
IFU_RRESP_ERR_EN: adds output inst_fault (1) and stores rresp[1] per queue entry. inst_fault=1 with the head when rresp was SLVERR/DECERR. Dropped responses never raise a fault. Without the macro, rresp is ignored and the port is absent.

Test Plan:
- Reset, enable=1, arready=1, slave returns mem[pc]=pc^32'hA5A5_0000 after 2 cycles, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching data, no gaps once the pipeline is filled.
- inst_ready=0, Q_DEPTH=4 -> exactly 4 ARs issued, no 5th ARVALID. Raise ready -> 4 entries in order, then fetching resumes.
- Redirect to 0x100 with 3 reads outstanding -> those 3 responses are dropped, and the next inst_pc is 0x100 with data from 0x100.
- Redirect while arvalid=1 and arready=0 for 3 cycles -> the AR completes unchanged, its response is dropped, and the next AR address is BASE_ADDR+redirect_pc.
- Two redirects 2 cycles apart (0x200 then 0x300) -> no instruction from 0x200 stream appears after the second redirect; first output PC is 0x300.
- With IFU_RRESP_ERR_EN, rresp=2'b10 for PC 8 -> inst_fault=1 only with inst_pc=8.

Source files
------------

// File: rtl/ifu_fetch_queue_if.sv
// AXI read-channel bundle between the fetch unit (master) and the instruction memory (slave).
interface ifu_fetch_queue_if #(
  parameter int CPU_W  = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [CPU_W-1:0]  rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: credit-limited single-beat AXI reads feeding a PC+instruction queue.
// Optional macro IFU_RRESP_ERR_EN adds the inst_fault output driven from rresp[1].
module ifu_fetch_queue #(
  parameter int                CPU_W     = 32,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                FETCH_ID  = 0,
  parameter int                OST_NUM   = 4,
  parameter int                Q_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter logic [CPU_W-1:0]  RESET_PC  = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     redirect_en,
  input  logic [CPU_W-1:0]         redirect_pc,
  ifu_fetch_queue_if.master        axi,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [CPU_W-1:0]         inst_pc,
  output logic [CPU_W-1:0]         inst_data,
`ifdef IFU_RRESP_ERR_EN
  output logic                     inst_fault,
`endif
  output logic [$clog2(OST_NUM):0] ost_cnt
);
  localparam int CW  = $clog2(OST_NUM) + 1;
  localparam int QW  = $clog2(Q_DEPTH) + 1;
  localparam int QPW = $clog2(Q_DEPTH);
  localparam int OPW = (OST_NUM > 1) ? $clog2(OST_NUM) : 1;
  localparam int SW  = CW + QW + 1;

  logic [CPU_W-1:0]  fetch_pc_r;
  logic [CPU_W-1:0]  req_pc_r;
  logic              arvalid_r;
  logic [ADDR_W-1:0] araddr_r;
  logic              ar_drop_r;
  logic [CW-1:0]     ost_r;
  logic [CW-1:0]     drop_r;
  logic [CPU_W-1:0]  pcf_mem_r [1 << OPW];
  logic [OPW-1:0]    pcf_wp_r;
  logic [OPW-1:0]    pcf_rp_r;
  logic [CPU_W-1:0]  q_pc_r    [Q_DEPTH];
  logic [CPU_W-1:0]  q_data_r  [Q_DEPTH];
  logic              q_flt_r   [Q_DEPTH];
  logic [QPW-1:0]    q_wp_r;
  logic [QPW-1:0]    q_rp_r;
  logic [QW-1:0]     q_cnt_r;

  logic          ar_hs_s, r_hs_s, drop_hit_s, q_push_s, q_pop_s, pend_s;
  logic          credit_s, issue_s;
  logic [SW-1:0] inflight_s, qload_s;
  logic [CW-1:0] ost_nxt_s, drop_nxt_s;
  logic          unused_s;

  assign ar_hs_s    = arvalid_r & axi.arready;
  assign r_hs_s     = axi.rvalid;
  assign drop_hit_s = r_hs_s & (drop_r != {CW{1'b0}});
  assign q_push_s   = r_hs_s & ~drop_hit_s & ~redirect_en;
  assign q_pop_s    = inst_valid & inst_ready & ~redirect_en;
  // A raised-but-unaccepted AR already owns a slot unless a redirect has charged it to drop_r.
  assign pend_s     = arvalid_r & ~ar_drop_r;
  assign inflight_s = SW'(drop_r) + SW'(ost_r) + SW'(pend_s);
  assign qload_s    = SW'(ost_r) + SW'(pend_s) + SW'(q_cnt_r) - SW'(q_pop_s);
  assign credit_s   = enable & ~redirect_en & (inflight_s < SW'(OST_NUM)) & (qload_s < SW'(Q_DEPTH));
  assign issue_s    = credit_s & (~arvalid_r | ar_hs_s);

  // Next outstanding/drop counts; a redirect moves every live request into the drop budget.
  always_comb begin
    ost_nxt_s  = ost_r;
    drop_nxt_s = drop_r;
    if (redirect_en) begin
      ost_nxt_s  = {CW{1'b0}};
      drop_nxt_s = CW'(SW'(drop_r) + SW'(ost_r) + SW'(pend_s) - SW'(r_hs_s));
    end else begin
      ost_nxt_s  = ost_r + CW'(ar_hs_s & ~ar_drop_r) - CW'(r_hs_s & ~drop_hit_s);
      drop_nxt_s = drop_r - CW'(drop_hit_s);
    end
  end

  // AR channel, fetch PC and request bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= {CPU_W{1'b0}};
      arvalid_r  <= 1'b0;
      araddr_r   <= {ADDR_W{1'b0}};
      ar_drop_r  <= 1'b0;
      ost_r      <= {CW{1'b0}};
      drop_r     <= {CW{1'b0}};
    end else begin
      ost_r  <= ost_nxt_s;
      drop_r <= drop_nxt_s;
      if (redirect_en) begin
        fetch_pc_r <= redirect_pc;
        arvalid_r  <= arvalid_r & ~ar_hs_s;
        ar_drop_r  <= arvalid_r & ~ar_hs_s;
      end else if (issue_s) begin
        arvalid_r  <= 1'b1;
        araddr_r   <= BASE_ADDR + ADDR_W'(fetch_pc_r);
        req_pc_r   <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + CPU_W'(32'd4);
        ar_drop_r  <= 1'b0;
      end else if (ar_hs_s) begin
        arvalid_r  <= 1'b0;
        ar_drop_r  <= 1'b0;
      end else begin
        arvalid_r  <= arvalid_r;
      end
    end
  end

  // PC side-FIFO: one entry per accepted AR, consumed by every response (kept or dropped).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_wp_r <= {OPW{1'b0}};
      pcf_rp_r <= {OPW{1'b0}};
      for (int i = 0; i < (1 << OPW); i++) pcf_mem_r[i] <= {CPU_W{1'b0}};
    end else begin
      if (ar_hs_s) begin
        pcf_mem_r[pcf_wp_r] <= req_pc_r;
        pcf_wp_r            <= pcf_wp_r + OPW'(1'b1);
      end
      if (r_hs_s) begin
        pcf_rp_r <= pcf_rp_r + OPW'(1'b1);
      end
    end
  end

  // Instruction queue; redirect empties it regardless of a concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wp_r  <= {QPW{1'b0}};
      q_rp_r  <= {QPW{1'b0}};
      q_cnt_r <= {QW{1'b0}};
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_pc_r[i]   <= {CPU_W{1'b0}};
        q_data_r[i] <= {CPU_W{1'b0}};
        q_flt_r[i]  <= 1'b0;
      end
    end else if (redirect_en) begin
      q_wp_r  <= {QPW{1'b0}};
      q_rp_r  <= {QPW{1'b0}};
      q_cnt_r <= {QW{1'b0}};
    end else begin
      if (q_push_s) begin
        q_pc_r[q_wp_r]   <= pcf_mem_r[pcf_rp_r];
        q_data_r[q_wp_r] <= axi.rdata;
        q_flt_r[q_wp_r]  <= axi.rresp[1];
        q_wp_r           <= q_wp_r + QPW'(1'b1);
      end
      if (q_pop_s) begin
        q_rp_r <= q_rp_r + QPW'(1'b1);
      end
      q_cnt_r <= q_cnt_r + QW'(q_push_s) - QW'(q_pop_s);
    end
  end

  assign inst_valid  = (q_cnt_r != {QW{1'b0}});
  assign inst_pc     = inst_valid ? q_pc_r[q_rp_r]   : {CPU_W{1'b0}};
  assign inst_data   = inst_valid ? q_data_r[q_rp_r] : {CPU_W{1'b0}};
  assign ost_cnt     = ost_r;

  assign axi.arvalid = arvalid_r;
  assign axi.araddr  = araddr_r;
  assign axi.arid    = ID_W'(FETCH_ID);
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.rready  = 1'b1;

`ifdef IFU_RRESP_ERR_EN
  assign inst_fault  = inst_valid & q_flt_r[q_rp_r];
  assign unused_s    = ^{axi.rlast, axi.rresp[0]};
`else
  assign unused_s    = ^{axi.rlast, axi.rresp};
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench: memory slave model with 2-cycle read latency and an expected-PC scoreboard.
module tb_ifu_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n, enable, redirect_en, inst_ready;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_pc, inst_data;
  logic [2:0]  ost_cnt;
`ifdef IFU_RRESP_ERR_EN
  logic        inst_fault;
`endif

  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.CPU_W(32), .ADDR_W(32), .ID_W(4)) bus ();

  ifu_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .axi(bus),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_data(inst_data),
`ifdef IFU_RRESP_ERR_EN
    .inst_fault(inst_fault),
`endif
    .ost_cnt(ost_cnt)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  typedef struct { logic [31:0] pc; int n; } phase_t;

  rsp_t        sq[$];
  logic [31:0] ar_log[$];
  logic [31:0] exp_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Memory slave: in-order responses two cycles after AR acceptance, SLVERR at address 8.
  initial begin
    rsp_t r;
    bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00; bus.rlast = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sq.delete();
        bus.rvalid = 1'b0;
      end else begin
        if (bus.arvalid && bus.arready) begin
          sq.push_back('{bus.araddr, cyc + 2});
          ar_log.push_back(bus.araddr);
        end
        if (sq.size() > 0 && sq[0].due <= cyc) begin
          r = sq.pop_front();
          bus.rvalid = 1'b1;
          bus.rdata  = r.addr ^ 32'hA5A5_0000;
          bus.rresp  = (r.addr == 32'h8) ? 2'b10 : 2'b00;
        end else begin
          bus.rvalid = 1'b0;
        end
      end
    end
  end

  // Scoreboard: each IDU handshake pops the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready && !redirect_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        hs_cyc.push_back(cyc);
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, e ^ 32'hA5A5_0000);
`ifdef IFU_RRESP_ERR_EN
        check("inst_fault", {31'd0, inst_fault}, {31'd0, (e == 32'h8)});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input int n);
    exp_q.delete();
    hs_cyc.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(pc + 32'(4 * k));
  endtask

  task automatic do_redirect(input logic [31:0] pc, input int n);
    tick();
    redirect_en = 1'b1;
    redirect_pc = pc;
    push_exp(pc, n);
    tick();
    redirect_en = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int k = 0; k < bound && exp_q.size() > 0; k++) tick();
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic int count_range(input logic [31:0] lo, input logic [31:0] hi);
    int c = 0;
    foreach (ar_log[k]) if (ar_log[k] >= lo && ar_log[k] < hi) c++;
    return c;
  endfunction

  initial begin
    phase_t      ph[3];
    logic [31:0] pend_addr;
    int          idx;
    ph[0] = '{32'h0000_0000, 8};
    ph[1] = '{32'h0000_0100, 6};
    ph[2] = '{32'h0000_0040, 5};

    rst_n = 1'b0; enable = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b0; bus.arready = 1'b0;
    repeat (3) tick();
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_ost_cnt", {29'd0, ost_cnt}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rready", {31'd0, bus.rready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Table-driven phases: sequential fetch from reset, then redirected streams.
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        push_exp(ph[i].pc, ph[i].n);
        enable = 1'b1; bus.arready = 1'b1; inst_ready = 1'b1;
      end else begin
        do_redirect(ph[i].pc, ph[i].n);
      end
      wait_empty(200);
      if (i == 0) begin
        check("arid", {28'd0, bus.arid}, 32'd0);
        check("arlen", {24'd0, bus.arlen}, 32'd0);
        check("arsize", {29'd0, bus.arsize}, 32'd2);
        check("arburst", {30'd0, bus.arburst}, 32'd1);
        if (hs_cyc.size() >= ph[i].n) check("gapless", 32'(hs_cyc[ph[i].n - 1] - hs_cyc[0]), 32'(ph[i].n - 1));
        else check("gapless_count", 32'(hs_cyc.size()), 32'(ph[i].n));
      end
    end

    // Backpressure: queue full stops fetching at exactly Q_DEPTH requests.
    inst_ready = 1'b0;
    do_redirect(32'h400, 8);
    repeat (30) tick();
    check("bp_ar_count", 32'(count_range(32'h400, 32'h500)), 32'd4);
    check("bp_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("bp_inst_pc", inst_pc, 32'h400);
    check("bp_ost_cnt", {29'd0, ost_cnt}, 32'd0);
    inst_ready = 1'b1;
    wait_empty(200);

    // Redirect while an AR is stalled: it completes unchanged and is dropped.
    bus.arready = 1'b0;
    for (int k = 0; k < 50 && !bus.arvalid; k++) tick();
    check("pend_arvalid", {31'd0, bus.arvalid}, 32'd1);
    pend_addr = bus.araddr;
    do_redirect(32'h600, 4);
    for (int k = 0; k < 3; k++) begin
      check("pend_hold_valid", {31'd0, bus.arvalid}, 32'd1);
      check("pend_hold_addr", bus.araddr, pend_addr);
      tick();
    end
    idx = ar_log.size();
    bus.arready = 1'b1;
    wait_empty(200);
    if (ar_log.size() > idx + 1) begin
      check("pend_ar_addr", ar_log[idx], pend_addr);
      check("post_redirect_addr", ar_log[idx + 1], 32'h600);
    end else begin
      check("pend_ar_log", 32'(ar_log.size()), 32'(idx + 2));
    end

    // Two redirects two cycles apart: only the second stream may appear.
    do_redirect(32'h200, 0);
    do_redirect(32'h300, 6);
    wait_empty(200);

    // Enable low: fetching stops and the pipe drains.
    enable = 1'b0;
    repeat (20) tick();
    check("dis_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("dis_ost_cnt", {29'd0, ost_cnt}, 32'd0);
    check("dis_inst_valid", {31'd0, inst_valid}, 32'd0);

    // Asynchronous reset with traffic in flight.
    enable = 1'b1;
    exp_q.delete();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("mrst_ost_cnt", {29'd0, ost_cnt}, 32'd0);
    check("mrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    push_exp(32'h0, 4);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_empty(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
